vnu_serial: RTL and testbench

VNU_SERIAL -- requirements
Module: vnu_serial

---
 rtl/ldpc_pkg.sv | 22 ++
 rtl/sat_sym.sv | 29 ++
 rtl/vnu_serial.sv | 133 +++++++++++++
 tb/tb_vnu_serial.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared LDPC decoder types, default widths and saturation limit
//
// Contents:
//   DATA_W_DEF   default signed message width (LLR, r, q)
//   vnu_state_t  variable-node FSM states IDLE / ACC / EMIT
//   sat_limit()  largest magnitude a message of width w may carry; the most
//                negative code is excluded so negated magnitudes stay symmetric
package ldpc_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2
    } vnu_state_t;

    function automatic int sat_limit(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/sat_sym.sv
// rtl/sat_sym.sv - symmetric saturation from accumulator width to message width
//
// Ports:
//   din   in  acc_w   signed value to clamp
//   dout  out data_w  din clamped to [-sat_limit(data_w), +sat_limit(data_w)]
// Purely combinational. Assumes acc_w > data_w.
module sat_sym
    import ldpc_pkg::*;
#(
    parameter int acc_w  = 10,
    parameter int data_w = DATA_W_DEF
) (
    input  logic signed [acc_w-1:0]  din,
    output logic signed [data_w-1:0] dout
);

    localparam logic signed [acc_w-1:0] pos_lim = acc_w'(sat_limit(data_w));
    localparam logic signed [acc_w-1:0] neg_lim = -pos_lim;

    always_comb begin
        dout = din[data_w-1:0];
        if (din > pos_lim) begin
            dout = pos_lim[data_w-1:0];
        end else if (din < neg_lim) begin
            dout = neg_lim[data_w-1:0];
        end
    end

endmodule

// File: rtl/vnu_serial.sv
// rtl/vnu_serial.sv - serial LDPC variable-node unit (accumulate, then emit extrinsics)
//
// Ports:
//   clk                        sole clock, rising edge
//   rst                        synchronous, active-low reset
//   llr_in/llr_valid/llr_ready channel LLR input stream, accepted in IDLE
//   r_in/r_valid/r_ready       D check-to-variable messages, accepted in ACC
//   q_out/q_valid/q_ready      D variable-to-check messages, emitted in EMIT
//   dec_bit/dec_valid          hard decision (1 = negative total), one-cycle strobe
//
// Per node: one LLR, then D r messages are buffered and summed with the LLR;
// then for each edge i in arrival order, q = sat(total - r[i]) is emitted.
// Minimum period per node is 1 + 2*D cycles.
module vnu_serial
    import ldpc_pkg::*;
#(
    parameter int data_w = DATA_W_DEF,
    parameter int D      = 3,
    parameter int acc_w  = data_w + $clog2(D + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [data_w-1:0] llr_in,
    input  logic                     llr_valid,
    output logic                     llr_ready,
    input  logic signed [data_w-1:0] r_in,
    input  logic                     r_valid,
    output logic                     r_ready,
    output logic signed [data_w-1:0] q_out,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic                     dec_bit,
    output logic                     dec_valid
);

    localparam int idx_w = (D > 1) ? $clog2(D) : 1;
    localparam logic [idx_w-1:0] last_idx = idx_w'(D - 1);

    vnu_state_t               state;
    logic signed [acc_w-1:0]  acc;
    logic [idx_w-1:0]         idx;
    logic signed [data_w-1:0] msg_buf [D];

    logic signed [acc_w-1:0]  llr_ext;
    logic signed [acc_w-1:0]  r_ext;
    logic signed [acc_w-1:0]  buf_ext;
    logic signed [acc_w-1:0]  sum_next;
    logic signed [acc_w-1:0]  extr;
    logic signed [data_w-1:0] buf_sel;

    assign llr_ext  = {{(acc_w - data_w){llr_in[data_w-1]}}, llr_in};
    assign r_ext    = {{(acc_w - data_w){r_in[data_w-1]}}, r_in};
    assign sum_next = acc + r_ext;

    // Extrinsic for the current edge: the full total minus that edge's own
    // input. Built only from registers so q_out has no path from any input.
    assign buf_sel = msg_buf[idx];
    assign buf_ext = {{(acc_w - data_w){buf_sel[data_w-1]}}, buf_sel};
    assign extr    = acc - buf_ext;

    sat_sym #(
        .acc_w  (acc_w),
        .data_w (data_w)
    ) u_sat (
        .din  (extr),
        .dout (q_out)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            for (int i = 0; i < D; i++) begin
                msg_buf[i] <= '0;
            end
            dec_bit   <= 1'b0;
            dec_valid <= 1'b0;
            llr_ready <= 1'b1;
            r_ready   <= 1'b0;
            q_valid   <= 1'b0;
        end else begin
            dec_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (llr_valid && llr_ready) begin
                        acc       <= llr_ext;
                        idx       <= '0;
                        state     <= ACC;
                        llr_ready <= 1'b0;
                        r_ready   <= 1'b1;
                    end
                end
                ACC: begin
                    if (r_valid && r_ready) begin
                        msg_buf[idx] <= r_in;
                        acc          <= sum_next;
                        if (idx == last_idx) begin
                            idx       <= '0;
                            state     <= EMIT;
                            dec_bit   <= sum_next[acc_w-1];
                            dec_valid <= 1'b1;
                            r_ready   <= 1'b0;
                            q_valid   <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (q_valid && q_ready) begin
                        if (idx == last_idx) begin
                            idx       <= '0;
                            state     <= IDLE;
                            q_valid   <= 1'b0;
                            llr_ready <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    llr_ready <= 1'b1;
                    r_ready   <= 1'b0;
                    q_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vnu_serial.sv
// tb/tb_vnu_serial.sv - directed self-checking bench for vnu_serial (data_w=8, D=3)
module tb_vnu_serial;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] llr_in;
    logic              llr_valid;
    logic              llr_ready;
    logic signed [7:0] r_in;
    logic              r_valid;
    logic              r_ready;
    logic signed [7:0] q_out;
    logic              q_valid;
    logic              q_ready;
    logic              dec_bit;
    logic              dec_valid;

    int errors = 0;
    int checks = 0;

    vnu_serial #(
        .data_w (8),
        .D      (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .llr_in    (llr_in),
        .llr_valid (llr_valid),
        .llr_ready (llr_ready),
        .r_in      (r_in),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .q_out     (q_out),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .dec_bit   (dec_bit),
        .dec_valid (dec_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, ".llr_ready"}, llr_ready, 1);
        check({nm, ".r_ready"},   r_ready,   0);
        check({nm, ".q_valid"},   q_valid,   0);
        check({nm, ".q_out"},     q_out,     0);
        check({nm, ".dec_bit"},   dec_bit,   0);
        check({nm, ".dec_valid"}, dec_valid, 0);
    endtask

    // Inputs change and outputs are sampled on the falling edge only.
    task automatic run_node(input string nm, input int llr,
                            input int r0, input int r1, input int r2,
                            input int q0, input int q1, input int q2,
                            input int dec, input bit gaps,
                            input int stall_edge, input int stall_n);
        int rv[3];
        int qv[3];
        rv = '{r0, r1, r2};
        qv = '{q0, q1, q2};
        check({nm, ".idle_llr_ready"}, llr_ready, 1);
        llr_in    = 8'(llr);
        llr_valid = 1'b1;
        @(negedge clk);
        llr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            int g;
            g = gaps ? int'($urandom_range(0, 3)) : 0;
            for (int k = 0; k < g; k++) begin
                r_valid   = 1'b0;
                llr_valid = 1'b1;
                llr_in    = 8'sd99;
                check({nm, ".gap_r_ready"}, r_ready, 1);
                check({nm, ".gap_q_valid"}, q_valid, 0);
                @(negedge clk);
            end
            llr_valid = 1'b0;
            check({nm, ".acc_r_ready"},   r_ready,   1);
            check({nm, ".acc_llr_ready"}, llr_ready, 0);
            r_in    = 8'(rv[i]);
            r_valid = 1'b1;
            @(negedge clk);
        end
        r_valid = 1'b0;
        check({nm, ".dec_valid"}, dec_valid, 1);
        check({nm, ".dec_bit"},   dec_bit,   dec);
        for (int i = 0; i < 3; i++) begin
            if (i == stall_edge) begin
                for (int k = 0; k < stall_n; k++) begin
                    q_ready = 1'b0;
                    check({nm, ".stall_q_valid"}, q_valid, 1);
                    check({nm, ".stall_q_out"},   q_out,   qv[i]);
                    @(negedge clk);
                end
            end
            q_ready = 1'b1;
            check({nm, ".q_valid"}, q_valid, 1);
            check({nm, ".q_out"},   q_out,   qv[i]);
            check({nm, ".q_not_min"}, (q_out == -8'sd128) ? 1 : 0, 0);
            if (i > 0) begin
                check({nm, ".dec_valid_once"}, dec_valid, 0);
            end
            @(negedge clk);
        end
        q_ready = 1'b0;
        check({nm, ".done_llr_ready"}, llr_ready, 1);
        check({nm, ".done_q_valid"},   q_valid,   0);
        check({nm, ".done_r_ready"},   r_ready,   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        llr_in    = '0;
        llr_valid = 1'b0;
        r_in      = '0;
        r_valid   = 1'b0;
        q_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        run_node("basic",   10, 5, -3, 7, 14, 22, 12, 0, 1'b0, -1, 0);
        run_node("sat_pos", 127, 127, 127, 127, 127, 127, 127, 0, 1'b0, -1, 0);
        run_node("sat_neg", -100, -100, -100, -128, -127, -127, -127, 1, 1'b0, -1, 0);
        run_node("neg",     -20, 3, -4, 1, -23, -16, -21, 1, 1'b0, -1, 0);
        run_node("stall",   10, 5, -3, 7, 14, 22, 12, 0, 1'b0, 1, 5);
        run_node("gaps",    10, 5, -3, 7, 14, 22, 12, 0, 1'b1, -1, 0);

        // Abort a node mid-ACC after two r transfers.
        llr_in    = 8'sd50;
        llr_valid = 1'b1;
        @(negedge clk);
        llr_valid = 1'b0;
        r_in      = 8'sd40;
        r_valid   = 1'b1;
        @(negedge clk);
        r_in      = -8'sd30;
        @(negedge clk);
        r_valid   = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_acc");
        rst = 1'b1;
        @(negedge clk);
        run_node("after_rst", 10, 5, -3, 7, 14, 22, 12, 0, 1'b0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
